// File: rtl/timer_regs_pkg.sv
// timer_regs_pkg: register map addresses and CONTROL/STATUS bit positions shared by the interval timer
package timer_regs_pkg;
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;
  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;
endpackage

// File: rtl/timer_count_core.sv
// timer_count_core: down-counter with reload at zero and a one-cycle timeout pulse on the rising edge of zero
// Ports: clk, reset_n (async, active low); run_i enables counting; load_i/load_val_i force a new count;
//        period_i reload value; count_o live count; reload_o high while a reload happens; timeout_o event pulse
module timer_count_core #(
  parameter int                 COUNT_W = 32,
  parameter logic [COUNT_W-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run_i,
  input  logic               load_i,
  input  logic [COUNT_W-1:0] load_val_i,
  input  logic [COUNT_W-1:0] period_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               reload_o,
  output logic               timeout_o
);
  logic [COUNT_W-1:0] count_q, count_d;
  logic               zero_q, is_zero;
  assign is_zero   = count_q == '0;
  assign reload_o  = run_i & is_zero;
  // zero_q remembers the previous cycle so the event fires once per arrival at zero
  assign timeout_o = is_zero & ~zero_q;
  assign count_o   = count_q;
  assign count_d   = load_i ? load_val_i :
                     run_i  ? (is_zero ? period_i : count_q - COUNT_W'(1)) : count_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count_q <= RST_VAL;
      zero_q  <= RST_VAL == '0;
    end else begin
      count_q <= count_d;
      zero_q  <= is_zero;
    end
endmodule

// File: rtl/param_interval_timer.sv
// param_interval_timer: programmable interval timer with a 16-bit register slave and level interrupt
// Ports: clk, reset_n (async, active low); address/chipselect/write_n/writedata slave write port;
//        readdata registered read data (1-cycle latency, no chipselect needed); irq = TO & ITO
module param_interval_timer
  import timer_regs_pkg::*;
#(
  parameter int          COUNT_W        = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0007A11F,
  parameter bit          RESET_RUNNING  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);
  localparam int                 HI_W       = COUNT_W - 16;
  localparam logic [COUNT_W-1:0] RST_PERIOD = DEFAULT_PERIOD[COUNT_W-1:0];
  logic [COUNT_W-1:0] period_q, period_d, snap_q, snap_d, count;
  logic               run_q, run_d, cont_q, cont_d, ito_q, ito_d, to_q, to_d;
  logic [15:0]        readdata_q, readdata_d, period_hi, snap_hi;
  logic               wr, wr_status, wr_ctrl, wr_pl, wr_ph, wr_snap, load, reload, timeout;
  assign wr        = chipselect & ~write_n;
  assign wr_status = wr & (address == ADDR_STATUS);
  assign wr_ctrl   = wr & (address == ADDR_CONTROL);
  assign wr_pl     = wr & (address == ADDR_PERIODL);
  assign wr_ph     = wr & (address == ADDR_PERIODH);
  assign wr_snap   = wr & (address == ADDR_SNAPL || address == ADDR_SNAPH);
  assign load      = wr_pl | wr_ph;
  assign period_d  = wr_pl ? {period_q[COUNT_W-1:16], writedata} :
                     wr_ph ? {writedata[HI_W-1:0], period_q[15:0]} : period_q;
  // STOP beats START; a control write beats the one-shot stop at reload
  assign run_d     = wr_ctrl && writedata[CTRL_STOP]  ? 1'b0 :
                     wr_ctrl && writedata[CTRL_START] ? 1'b1 :
                     load                             ? 1'b0 :
                     reload && !cont_q                ? 1'b0 : run_q;
  assign cont_d    = wr_ctrl ? writedata[CTRL_CONT] : cont_q;
  assign ito_d     = wr_ctrl ? writedata[CTRL_ITO]  : ito_q;
  assign to_d      = timeout ? 1'b1 : wr_status ? 1'b0 : to_q;
  assign snap_d    = wr_snap ? count : snap_q;
  // upper halves zero-extend so unimplemented high bits read 0
  assign period_hi = 16'(period_q >> 16);
  assign snap_hi   = 16'(snap_q >> 16);
  assign readdata_d = address == ADDR_STATUS  ? {14'd0, run_q, to_q}   :
                      address == ADDR_CONTROL ? {14'd0, cont_q, ito_q} :
                      address == ADDR_PERIODL ? period_q[15:0]         :
                      address == ADDR_PERIODH ? period_hi              :
                      address == ADDR_SNAPL   ? snap_q[15:0]           :
                      address == ADDR_SNAPH   ? snap_hi                : 16'd0;
  assign readdata = readdata_q;
  assign irq      = to_q & ito_q;
  timer_count_core #(.COUNT_W(COUNT_W), .RST_VAL(RST_PERIOD)) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .run_i     (run_q),
    .load_i    (load),
    .load_val_i(period_d),
    .period_i  (period_q),
    .count_o   (count),
    .reload_o  (reload),
    .timeout_o (timeout)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      period_q   <= RST_PERIOD;
      snap_q     <= '0;
      run_q      <= RESET_RUNNING;
      cont_q     <= 1'b1;
      ito_q      <= 1'b0;
      to_q       <= 1'b0;
      readdata_q <= '0;
    end else begin
      period_q   <= period_d;
      snap_q     <= snap_d;
      run_q      <= run_d;
      cont_q     <= cont_d;
      ito_q      <= ito_d;
      to_q       <= to_d;
      readdata_q <= readdata_d;
    end
endmodule
